// File: rtl/button_input_unit.sv
// Input conditioning for the pet controller: synchronise and debounce the board keys and tilt
// sensor, emit one-cycle action pulses, and run the long/short-press test-mode protocol.
module button_input_unit #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 250000000,
    parameter int SEL_MAX           = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_sleep_n,
    input  logic       btn_awake_n,
    input  logic       btn_feed_n,
    input  logic       btn_play_n,
    input  logic       btn_test_n,
    input  logic       giro_raw,
    output logic       sleep_pulse,
    output logic       awake_pulse,
    output logic       feed_pulse,
    output logic       play_pulse,
    output logic       giro,
    output logic       test_mode,
    output logic [3:0] test_sel
);

    localparam int N_IN   = 6;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = '1;
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [3:0]        SEL_TOP   = 4'(SEL_MAX);
    localparam logic [3:0]        SEL_ONE   = 4'd1;

    // Channel order: 0 sleep, 1 awake, 2 feed, 3 play, 4 test, 5 giro.
    // Idle raw level: keys high (active-low), tilt low; also the key-inversion mask.
    localparam logic [N_IN-1:0] RAW_IDLE = 6'b01_1111;
    localparam int CH_TEST = 4;
    localparam int CH_GIRO = 5;

    typedef enum logic [1:0] {
        T_IDLE,
        T_HOLD,
        T_WAIT_REL
    } t_state_e;

    logic [N_IN-1:0]   w_raw;
    logic [N_IN-1:0]   r_sync1;
    logic [N_IN-1:0]   r_sync2;
    logic [N_IN-1:0]   w_sync;
    logic [N_IN-1:0]   r_stable;
    logic [DB_W-1:0]   r_db_cnt [N_IN];
    logic [N_IN-1:0]   w_db_done;
    logic [N_IN-1:0]   w_rise;
    logic [3:0]        r_pulse;
    logic              w_test_key;
    t_state_e          r_t_state;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_test_mode;
    logic [3:0]        r_test_sel;

    assign w_raw = {giro_raw, btn_test_n, btn_play_n, btn_feed_n, btn_awake_n, btn_sleep_n};

    // NOTE: sequential state uses non-blocking assignments so r_sync2 samples the old r_sync1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= RAW_IDLE;
            r_sync2 <= RAW_IDLE;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Keys become active-high after the synchroniser; the tilt bit passes unchanged.
    assign w_sync = r_sync2 ^ RAW_IDLE;

    always_comb begin
        w_db_done = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_db_done[i] = (w_sync[i] != r_stable[i]) && (r_db_cnt[i] == DB_LAST);
        end
    end

    // A channel whose new accepted level is 1 is a debounced 0->1 transition.
    assign w_rise = w_db_done & w_sync;

    // NOTE: the counter array is small and must start cleared, so it is reset like any flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (w_sync[i] == r_stable[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_db_done[i]) begin
                    r_stable[i] <= w_sync[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_ONE;
                end
            end
        end
    end

    // Pulses rise on the same edge as the debounced level; muted while in test mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pulse <= '0;
        end else begin
            r_pulse <= w_rise[3:0] & {4{~r_test_mode}};
        end
    end

    assign w_test_key = r_stable[CH_TEST];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_t_state   <= T_IDLE;
            r_hold_cnt  <= '0;
            r_test_mode <= 1'b0;
            r_test_sel  <= '0;
        end else begin
            case (r_t_state)
                T_IDLE: begin
                    if (w_test_key) begin
                        r_t_state  <= T_HOLD;
                        r_hold_cnt <= '0;
                    end
                end
                T_HOLD: begin
                    if (w_test_key) begin
                        if (r_hold_cnt == HOLD_LAST) begin
                            r_test_mode <= ~r_test_mode;
                            // Selection restarts on entry and is frozen on exit for the consumer.
                            if (!r_test_mode) begin
                                r_test_sel <= '0;
                            end
                            r_t_state <= T_WAIT_REL;
                        end else if (r_hold_cnt != HOLD_SAT) begin
                            r_hold_cnt <= r_hold_cnt + HOLD_ONE;
                        end
                    end else begin
                        if (r_test_mode) begin
                            if (r_test_sel >= SEL_TOP) begin
                                r_test_sel <= SEL_ONE;
                            end else begin
                                r_test_sel <= r_test_sel + SEL_ONE;
                            end
                        end
                        r_t_state <= T_IDLE;
                    end
                end
                T_WAIT_REL: begin
                    if (!w_test_key) begin
                        r_t_state <= T_IDLE;
                    end
                end
                default: r_t_state <= T_IDLE;
            endcase
        end
    end

    assign sleep_pulse = r_pulse[0];
    assign awake_pulse = r_pulse[1];
    assign feed_pulse  = r_pulse[2];
    assign play_pulse  = r_pulse[3];
    assign giro        = r_stable[CH_GIRO];
    assign test_mode   = r_test_mode;
    assign test_sel    = r_test_sel;

endmodule

// File: tb/tb_button_input_unit.sv
// Directed bench for button_input_unit with short debounce/long-press thresholds.
module tb_button_input_unit;

    localparam int DB = 4;
    localparam int LP = 20;

    logic       clk;
    logic       rst;
    logic       btn_sleep_n;
    logic       btn_awake_n;
    logic       btn_feed_n;
    logic       btn_play_n;
    logic       btn_test_n;
    logic       giro_raw;
    logic       sleep_pulse;
    logic       awake_pulse;
    logic       feed_pulse;
    logic       play_pulse;
    logic       giro;
    logic       test_mode;
    logic [3:0] test_sel;

    int checks = 0;
    int errors = 0;
    int n_sleep = 0;
    int n_awake = 0;
    int n_feed  = 0;
    int n_play  = 0;
    int n_mode_rise = 0;
    logic prev_mode = 1'b0;
    int base;

    button_input_unit #(
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP),
        .SEL_MAX          (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_sleep_n(btn_sleep_n),
        .btn_awake_n(btn_awake_n),
        .btn_feed_n (btn_feed_n),
        .btn_play_n (btn_play_n),
        .btn_test_n (btn_test_n),
        .giro_raw   (giro_raw),
        .sleep_pulse(sleep_pulse),
        .awake_pulse(awake_pulse),
        .feed_pulse (feed_pulse),
        .play_pulse (play_pulse),
        .giro       (giro),
        .test_mode  (test_mode),
        .test_sel   (test_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse and test-mode entry counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (sleep_pulse) n_sleep <= n_sleep + 1;
        if (awake_pulse) n_awake <= n_awake + 1;
        if (feed_pulse)  n_feed  <= n_feed + 1;
        if (play_pulse)  n_play  <= n_play + 1;
        if (test_mode && !prev_mode) n_mode_rise <= n_mode_rise + 1;
        prev_mode <= test_mode;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic short_press();
        btn_test_n = 1'b0;
        tick(8);
        btn_test_n = 1'b1;
        tick(12);
    endtask

    task automatic long_press();
        btn_test_n = 1'b0;
        tick(40);
        btn_test_n = 1'b1;
        tick(12);
    endtask

    initial begin
        rst = 1'b1;
        btn_sleep_n = 1'b1;
        btn_awake_n = 1'b1;
        btn_feed_n  = 1'b1;
        btn_play_n  = 1'b1;
        btn_test_n  = 1'b1;
        giro_raw    = 1'b0;
        tick(3);
        check("rst_sleep", sleep_pulse, 0);
        check("rst_feed", feed_pulse, 0);
        check("rst_giro", giro, 0);
        check("rst_mode", test_mode, 0);
        check("rst_sel", test_sel, 0);
        rst = 1'b0;
        tick(2);

        // Held feed key: single pulse exactly DB+2 edges after the first low sample.
        base = n_feed;
        btn_feed_n = 1'b0;
        tick(DB + 1);
        check("feed_early", feed_pulse, 0);
        tick(1);
        check("feed_pulse", feed_pulse, 1);
        tick(1);
        check("feed_one_cycle", feed_pulse, 0);
        tick(100);
        check("feed_hold_count", n_feed - base, 1);
        btn_feed_n = 1'b1;
        tick(10);
        check("feed_release_count", n_feed - base, 1);
        check("awake_quiet", n_awake, 0);

        // Bouncing play key is rejected, a clean press is accepted once.
        base = n_play;
        btn_play_n = 1'b0;
        tick(3);
        btn_play_n = 1'b1;
        tick(1);
        btn_play_n = 1'b0;
        tick(3);
        btn_play_n = 1'b1;
        tick(10);
        check("play_bounce", n_play - base, 0);
        btn_play_n = 1'b0;
        tick(10);
        btn_play_n = 1'b1;
        tick(10);
        check("play_clean", n_play - base, 1);

        // Long press enters test mode once, at DB+2 + 1 + LP edges.
        base = n_mode_rise;
        btn_test_n = 1'b0;
        tick(26);
        check("lp_before", test_mode, 0);
        tick(1);
        check("lp_enter", test_mode, 1);
        check("lp_sel0", test_sel, 0);
        tick(13);
        btn_test_n = 1'b1;
        tick(12);
        check("lp_still_on", test_mode, 1);
        check("lp_single_toggle", n_mode_rise - base, 1);

        for (int k = 1; k <= 3; k++) begin
            short_press();
            check("sp_sel", test_sel, k);
        end
        long_press();
        check("exit_mode", test_mode, 0);
        check("exit_sel_frozen", test_sel, 3);

        // Full selection walk with wrap, and key masking while in test mode.
        long_press();
        check("reenter_mode", test_mode, 1);
        check("reenter_sel0", test_sel, 0);
        for (int k = 0; k < 10; k++) begin
            short_press();
            check("walk_sel", test_sel, (k % 9) + 1);
        end
        base = n_sleep;
        btn_sleep_n = 1'b0;
        tick(DB + 2);
        check("mask_sleep_edge", sleep_pulse, 0);
        tick(4);
        btn_sleep_n = 1'b1;
        tick(10);
        check("mask_sleep_count", n_sleep - base, 0);
        long_press();
        check("exit2_mode", test_mode, 0);
        check("exit2_sel", test_sel, 1);
        short_press();
        check("idle_short_noop", test_sel, 1);

        // Simultaneous sleep+play, then tilt latency.
        btn_sleep_n = 1'b0;
        btn_play_n  = 1'b0;
        tick(DB + 2);
        check("dual_sleep", sleep_pulse, 1);
        check("dual_play", play_pulse, 1);
        tick(1);
        check("dual_sleep_off", sleep_pulse, 0);
        check("dual_play_off", play_pulse, 0);
        btn_sleep_n = 1'b1;
        btn_play_n  = 1'b1;
        tick(10);
        giro_raw = 1'b1;
        tick(DB + 1);
        check("giro_early", giro, 0);
        tick(1);
        check("giro_high", giro, 1);

        // Reset mid-long-press while in test mode; held key needs a full new long press.
        long_press();
        short_press();
        check("pre_rst_sel", test_sel, 1);
        btn_test_n = 1'b0;
        tick(22);
        check("pre_rst_mode", test_mode, 1);
        check("pre_rst_giro", giro, 1);
        rst = 1'b1;
        #1;
        check("arst_mode", test_mode, 0);
        check("arst_sel", test_sel, 0);
        check("arst_giro", giro, 0);
        check("arst_pulses", {sleep_pulse, awake_pulse, feed_pulse, play_pulse}, 0);
        tick(2);
        rst = 1'b0;
        tick(26);
        check("post_rst_before", test_mode, 0);
        tick(1);
        check("post_rst_enter", test_mode, 1);
        check("post_rst_sel", test_sel, 0);
        btn_test_n = 1'b1;
        tick(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
